// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, decode control inputs and the registered instruction outputs.
// master = fetch unit, slave = decode/ROM/testbench side.
interface fetch_unit_if;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        BranchEn;
  logic        BranchRel;
  logic [9:0]  Target;
  logic [7:0]  Offset;
  logic [8:0]  InstIn;
  logic [9:0]  InstAddress;
  logic [8:0]  InstReg;
  logic [9:0]  InstPC;
  logic        InstValid;
  logic        Done;
  logic [15:0] CycleCount;

  modport master (
    input  Start, Halt, Stall, BranchEn, BranchRel, Target, Offset, InstIn,
    output InstAddress, InstReg, InstPC, InstValid, Done, CycleCount
  );

  modport slave (
    output Start, Halt, Stall, BranchEn, BranchRel, Target, Offset, InstIn,
    input  InstAddress, InstReg, InstPC, InstValid, Done, CycleCount
  );
endinterface

// File: rtl/fetch_unit.sv
// PC + fetch stage: one instruction per cycle, registered one edge after its address is presented;
// Stall freezes fetch state, a taken branch costs one squashed bubble, Halt parks the unit until Start.
module fetch_unit #(
  parameter logic [9:0] START_ADDR = 10'd0
) (
  input logic          Clk,
  input logic          Reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [9:0]  inst_pc_q, inst_pc_d;
  logic [8:0]  inst_q, inst_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [15:0] cc_q, cc_d;
  logic [9:0]  br_target;

  // Relative branches are taken from the address of the branch itself, wrapping modulo 1024.
  assign br_target = bus.BranchRel ? (inst_pc_q + {{2{bus.Offset[7]}}, bus.Offset})
                                   : bus.Target;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    vld_d     = vld_q;
    done_d    = done_q;
    cc_d      = cc_q;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cc_d    = 16'd0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (cc_q != 16'hFFFF) begin
          cc_d = cc_q + 16'd1;
        end
        if (bus.Halt && vld_q) begin
          state_d = HALTED;
          done_d  = 1'b1;
          vld_d   = 1'b0;
        end else if (!bus.Stall) begin
          if (bus.BranchEn && vld_q) begin
            // The word currently on InstIn was fetched down the wrong path: drop it.
            pc_d  = br_target;
            vld_d = 1'b0;
          end else begin
            inst_d    = bus.InstIn;
            inst_pc_d = pc_q;
            vld_d     = 1'b1;
            pc_d      = pc_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= 10'd0;
      inst_pc_q <= 10'd0;
      inst_q    <= 9'h000;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      cc_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      cc_q      <= cc_d;
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.InstReg     = inst_q;
  assign bus.InstPC      = inst_pc_q;
  assign bus.InstValid   = vld_q;
  assign bus.Done        = done_q;
  assign bus.CycleCount  = cc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program counter and fetch stage for the 3BC processor. Drives the 10-bit address into the instruction ROM, registers the 9-bit instruction word it returns, and presents it to decode with a valid flag. Handles absolute and PC-relative branches (one-cycle squash), stalls, halt, and a start/done handshake with the testbench.

## Interface
- START_ADDR, 10'd0, address of the first instruction after Start
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low; sampled on rising edge of Clk
- Start  in  1  begin program execution; honoured in IDLE or HALTED only
- Halt  in  1  from decode: current InstReg is a halt instruction
- Stall  in  1  from downstream: hold fetch state this cycle
- BranchEn  in  1  from decode: current InstReg is a taken branch
- BranchRel  in  1  1 = PC-relative (InstPC + Offset), 0 = absolute (Target)
- Target  in  10  absolute branch target
- Offset  in  8  signed two's-complement relative branch offset
- InstIn  in  9  instruction word returned by the ROM for InstAddress
- InstAddress  out  10  combinational copy of PC, to the ROM
- InstReg  out  9  registered instruction presented to decode
- InstPC  out  10  address InstReg was fetched from
- InstValid  out  1  InstReg holds a live instruction
- Done  out  1  program has halted
- CycleCount  out  16  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- Reset values: PC=0, InstReg=9'h000, InstPC=0, InstValid=0, Done=0, CycleCount=0.
- IDLE: all registers hold. Start=1 -> PC<=START_ADDR, CycleCount<=0, Done<=0, go RUN.
- RUN, per edge, priority highest first:
  - Halt=1 and InstValid=1 -> go HALTED, Done<=1, InstValid<=0, PC holds.
  - Stall=1 -> PC, InstReg, InstPC, InstValid hold; BranchEn ignored this cycle (decode keeps it asserted).
  - BranchEn=1 and InstValid=1 -> PC<=target, InstValid<=0 (squash the word fetched at PC); InstReg/InstPC hold.
  - Otherwise -> InstReg<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1.
- Halt and BranchEn with InstValid=0 are ignored.
- Target: BranchRel=0 -> Target; BranchRel=1 -> InstPC + sign-extend(Offset) to 10 bits, modulo 1024.
- PC increment wraps 1023 -> 0; no error flag.
- CycleCount increments every edge spent in RUN (including stall cycles), saturates at 16'hFFFF.
- HALTED: registers hold, Done stays 1. Start=1 -> restart exactly as from IDLE (Done<=0).
- Start in RUN is ignored.
- Reset low at any edge, any state, overrides everything and returns to reset values next cycle.

## Timing
- InstAddress = PC combinationally; ROM assumed combinational, InstIn valid same cycle.
- Start sampled at edge k -> RUN from k; first valid InstReg (address START_ADDR) after edge k+1.
- Sequential throughput: one instruction per cycle when not stalled.
- Taken branch: BranchEn at edge b -> InstValid=0 for cycle after b; target instruction valid after edge b+1 (one bubble).
- Halt at edge h -> Done=1 and InstValid=0 after edge h.
- Stall adds exactly one cycle per asserted cycle; no instruction lost or duplicated.

## Test plan
- Reset/start: Reset=0 two cycles, check all outputs zero; Start pulse with START_ADDR=0, ROM[0..3]=9'h011,9'h022,9'h033,9'h044 -> InstReg sequence 011,022,033,044 on consecutive cycles, InstPC 0..3.
- Absolute branch: BranchEn=1, BranchRel=0, Target=10'd100 while InstPC=2 -> one cycle InstValid=0, then InstPC=100, InstReg=ROM[100].
- Relative branch backward/wrap: InstPC=3, Offset=8'hF6 (-10) -> next valid InstPC=1017; PC at 1023 advances to 0.
- Stall: Stall=1 for 3 cycles at InstPC=5 with BranchEn=1 -> InstReg/InstPC frozen, no redirect; on release branch taken once.
- Halt/restart: Halt=1 at InstPC=7 -> Done=1, InstValid=0, CycleCount frozen; Start -> Done=0, CycleCount=0, fetch resumes at START_ADDR.
- Reset mid-run and saturation: Reset=0 during RUN -> IDLE, zeros next cycle; force 70000 RUN cycles -> CycleCount=16'hFFFF.
